// File: rtl/key_scan_encoder_16.sv
// key_scan_encoder_16
// Sequential 16-line key encoder. It drives the address of an external
// 4-to-16 active-low decoder, reads back one shared active-low sense line,
// debounces the first closed key it finds, and hands it to the CPU as a
// 4-bit code with a valid/ack handshake.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET1     in   asynchronous reset, active low
//   SCAN_EN    in   1 = scanning allowed
//   SENSE_N    in   asynchronous sense return, 0 = selected row's key closed
//   KEY_ACK    in   consumer accepts KEY_CODE (only honoured while KEY_VALID=1)
//   ROW_SEL    out  [3:0] decoder address
//   DEC_EN_N   out  decoder enable, active low, asserted whenever not idle
//   KEY_CODE   out  [3:0] reported row index
//   KEY_VALID  out  key available
//   BUSY       out  1 whenever not idle
module key_scan_encoder_16 #(
  parameter int SETTLE_CYCLES  = 3,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RESET1,
  input  logic       SCAN_EN,
  input  logic       SENSE_N,
  input  logic       KEY_ACK,
  output logic [3:0] ROW_SEL,
  output logic       DEC_EN_N,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DEBOUNCE,
    REPORT,
    RELEASE
  } state_t;

  // Compare values: the counter sits at "target-1" on the edge where the
  // target is reached, so these are the terminal counts.
  localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic [3:0]       row_next;
  logic [3:0]       code_next;
  logic             valid_next;

  logic sense_meta;
  logic sense_sync;
  logic pressed;

  // Two-flop synchronizer on the asynchronous sense line. Both stages reset
  // to 1 so the FSM sees "released" right after reset.
  always_ff @(posedge CLK or negedge RESET1) begin
    if (!RESET1) begin
      sense_meta <= 1'b1;
      sense_sync <= 1'b1;
    end else begin
      sense_meta <= SENSE_N;
      sense_sync <= sense_meta;
    end
  end

  assign pressed = ~sense_sync;

  // State register plus the registered outputs that the FSM owns.
  always_ff @(posedge CLK or negedge RESET1) begin
    if (!RESET1) begin
      state     <= IDLE;
      count     <= '0;
      ROW_SEL   <= 4'd0;
      KEY_CODE  <= 4'd0;
      KEY_VALID <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      ROW_SEL   <= row_next;
      KEY_CODE  <= code_next;
      KEY_VALID <= valid_next;
    end
  end

  // Next-state logic. The row counter only moves when a row is rejected
  // (no key, bounce) or a reported key has been released, so the scan always
  // resumes from the row after the last one examined. SETTLE_CYCLES covers
  // the synchronizer latency, so the sample taken at the end of a settle
  // window reflects the currently selected row.
  always_comb begin
    state_next = state;
    count_next = count;
    row_next   = ROW_SEL;
    code_next  = KEY_CODE;
    valid_next = KEY_VALID;

    unique case (state)
      IDLE: begin
        if (SCAN_EN) begin
          state_next = SETTLE;
          count_next = '0;
        end
      end

      SETTLE: begin
        if (!SCAN_EN) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == SETTLE_LAST) begin
          if (pressed) begin
            // The settle sample already counts as the first pressed sample.
            state_next = DEBOUNCE;
            count_next = CNT_ONE;
          end else begin
            row_next   = ROW_SEL + 4'd1;
            count_next = '0;
          end
        end else begin
          count_next = count + CNT_ONE;
        end
      end

      DEBOUNCE: begin
        if (!SCAN_EN) begin
          state_next = IDLE;
          count_next = '0;
        end else if (!pressed) begin
          state_next = SETTLE;
          row_next   = ROW_SEL + 4'd1;
          count_next = '0;
        end else if (count == DEBOUNCE_LAST) begin
          state_next = REPORT;
          code_next  = ROW_SEL;
          valid_next = 1'b1;
          count_next = '0;
        end else begin
          count_next = count + CNT_ONE;
        end
      end

      REPORT: begin
        // SCAN_EN is deliberately ignored here: the handshake always completes.
        if (KEY_ACK) begin
          state_next = RELEASE;
          valid_next = 1'b0;
          count_next = '0;
        end
      end

      RELEASE: begin
        // Only an unbroken run of released samples ends the key, which is what
        // stops a held key from being reported twice.
        if (pressed) begin
          count_next = '0;
        end else if (count == DEBOUNCE_LAST) begin
          state_next = SCAN_EN ? SETTLE : IDLE;
          row_next   = ROW_SEL + 4'd1;
          count_next = '0;
        end else begin
          count_next = count + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  assign BUSY     = (state != IDLE);
  assign DEC_EN_N = (state == IDLE);

endmodule
